// File: rtl/ping_pong_merger_if.sv
// AXI-Stream bundle for the ping-pong merger: two packetized inputs and one merged output.
interface ping_pong_merger_if;
  logic [511:0] AXIS_IN0_TDATA;
  logic         AXIS_IN0_TLAST;
  logic         AXIS_IN0_TVALID;
  logic         AXIS_IN0_TREADY;
  logic [511:0] AXIS_IN1_TDATA;
  logic         AXIS_IN1_TLAST;
  logic         AXIS_IN1_TVALID;
  logic         AXIS_IN1_TREADY;
  logic [511:0] AXIS_OUT_TDATA;
  logic         AXIS_OUT_TLAST;
  logic         AXIS_OUT_TVALID;
  logic         AXIS_OUT_TREADY;

  modport master (
    output AXIS_IN0_TDATA, AXIS_IN0_TLAST, AXIS_IN0_TVALID,
    input  AXIS_IN0_TREADY,
    output AXIS_IN1_TDATA, AXIS_IN1_TLAST, AXIS_IN1_TVALID,
    input  AXIS_IN1_TREADY,
    input  AXIS_OUT_TDATA, AXIS_OUT_TLAST, AXIS_OUT_TVALID,
    output AXIS_OUT_TREADY
  );

  modport slave (
    input  AXIS_IN0_TDATA, AXIS_IN0_TLAST, AXIS_IN0_TVALID,
    output AXIS_IN0_TREADY,
    input  AXIS_IN1_TDATA, AXIS_IN1_TLAST, AXIS_IN1_TVALID,
    output AXIS_IN1_TREADY,
    output AXIS_OUT_TDATA, AXIS_OUT_TLAST, AXIS_OUT_TVALID,
    input  AXIS_OUT_TREADY
  );
endinterface

// File: rtl/ping_pong_merger.sv
// Merges two ping-pong split AXI-Stream paths back into one stream, taking whole
// packets in groups of PACKETS_PER_GROUP from each input through a two-entry skid buffer.
module ping_pong_merger (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [15:0]          PACKETS_PER_GROUP,
  ping_pong_merger_if.slave    axis,
  output logic                 INPUT_SELECT,
  output logic [31:0]          PACKET_COUNT
);

  typedef enum logic {SEL_IN0 = 1'b0, SEL_IN1 = 1'b1} sel_e;

  sel_e         sel_q, sel_d;
  logic [15:0]  pktCnt_q, pktCnt_d;
  logic [15:0]  ppg_q, ppg_d;
  logic         mainValid_q, mainValid_d;
  logic         mainLast_q, mainLast_d;
  logic [511:0] mainData_q, mainData_d;
  logic         skidValid_q, skidValid_d;
  logic         skidLast_q, skidLast_d;
  logic [511:0] skidData_q, skidData_d;
  logic [31:0]  pktTotal_q, pktTotal_d;

  logic [15:0]  ppgEff;
  logic         inReady;
  logic         inValid;
  logic         inLast;
  logic [511:0] inData;
  logic         inHs;
  logic         outHs;

  assign ppgEff = (PACKETS_PER_GROUP == 16'd0) ? 16'd1 : PACKETS_PER_GROUP;

  // Ready depends only on the skid register, so downstream ready never reaches the inputs.
  assign inReady = resetn & ~skidValid_q;
  assign axis.AXIS_IN0_TREADY = inReady & (sel_q == SEL_IN0);
  assign axis.AXIS_IN1_TREADY = inReady & (sel_q == SEL_IN1);

  always_comb begin
    inValid = axis.AXIS_IN0_TVALID;
    inLast  = axis.AXIS_IN0_TLAST;
    inData  = axis.AXIS_IN0_TDATA;
    if (sel_q == SEL_IN1) begin
      inValid = axis.AXIS_IN1_TVALID;
      inLast  = axis.AXIS_IN1_TLAST;
      inData  = axis.AXIS_IN1_TDATA;
    end
  end

  assign inHs  = inValid & inReady;
  assign outHs = mainValid_q & axis.AXIS_OUT_TREADY;

  always_comb begin
    sel_d       = sel_q;
    pktCnt_d    = pktCnt_q;
    ppg_d       = ppg_q;
    mainValid_d = mainValid_q;
    mainLast_d  = mainLast_q;
    mainData_d  = mainData_q;
    skidValid_d = skidValid_q;
    skidLast_d  = skidLast_q;
    skidData_d  = skidData_q;
    pktTotal_d  = pktTotal_q;

    if (inHs && inLast) begin
      if (pktCnt_q < ppg_q) begin
        pktCnt_d = pktCnt_q + 16'd1;
      end else begin
        pktCnt_d = 16'd1;
        sel_d    = (sel_q == SEL_IN0) ? SEL_IN1 : SEL_IN0;
        ppg_d    = ppgEff;
      end
    end

    if (outHs) begin
      mainValid_d = skidValid_q;
      skidValid_d = 1'b0;
      if (skidValid_q) begin
        mainLast_d = skidLast_q;
        mainData_d = skidData_q;
      end
      if (mainLast_q) begin
        pktTotal_d = pktTotal_q + 32'd1;
      end
    end

    // An accepted beat implies the skid is empty, so it lands in main whenever main frees up.
    if (inHs) begin
      if (!mainValid_q || outHs) begin
        mainValid_d = 1'b1;
        mainLast_d  = inLast;
        mainData_d  = inData;
      end else begin
        skidValid_d = 1'b1;
        skidLast_d  = inLast;
        skidData_d  = inData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_q       <= SEL_IN0;
      pktCnt_q    <= 16'd1;
      ppg_q       <= ppgEff;
      mainValid_q <= 1'b0;
      mainLast_q  <= 1'b0;
      mainData_q  <= '0;
      skidValid_q <= 1'b0;
      skidLast_q  <= 1'b0;
      skidData_q  <= '0;
      pktTotal_q  <= 32'd0;
    end else begin
      sel_q       <= sel_d;
      pktCnt_q    <= pktCnt_d;
      ppg_q       <= ppg_d;
      mainValid_q <= mainValid_d;
      mainLast_q  <= mainLast_d;
      mainData_q  <= mainData_d;
      skidValid_q <= skidValid_d;
      skidLast_q  <= skidLast_d;
      skidData_q  <= skidData_d;
      pktTotal_q  <= pktTotal_d;
    end
  end

  assign axis.AXIS_OUT_TDATA  = mainData_q;
  assign axis.AXIS_OUT_TLAST  = mainLast_q;
  assign axis.AXIS_OUT_TVALID = mainValid_q;
  assign INPUT_SELECT         = (sel_q == SEL_IN1);
  assign PACKET_COUNT         = pktTotal_q;

endmodule

// File: doc/ping_pong_merger.md
# ping_pong_merger

Reassembles a single 512-bit AXI-Stream from two packetized streams that were split in ping-pong fashion. It accepts whole packets (TLAST-delimited) from input 0 for a programmable number of packets, then switches to input 1 for the same number, alternating indefinitely. It sits downstream of the ping-pong splitter's two paths (e.g. after per-path buffering or a link) and restores the original beat order into one stream through a registered, full-throughput output stage.

## Interface
- No parameters; data width fixed at 512 bits.
- clk  input  1  clock
- resetn  input  1  Reset: synchronous, active-low.
- PACKETS_PER_GROUP  input  16  packets taken from one input before switching; 0 treated as 1
- AXIS_IN0_TDATA / AXIS_IN1_TDATA  input  512  packet data
- AXIS_IN0_TLAST / AXIS_IN1_TLAST  input  1  last beat of packet
- AXIS_IN0_TVALID / AXIS_IN1_TVALID  input  1  beat valid
- AXIS_IN0_TREADY / AXIS_IN1_TREADY  output  1  beat accepted
- AXIS_OUT_TDATA  output  512  merged data
- AXIS_OUT_TLAST  output  1  last beat of packet, copied from source
- AXIS_OUT_TVALID  output  1  beat valid
- AXIS_OUT_TREADY  input  1  downstream ready
- INPUT_SELECT  output  1  input currently being drained
- PACKET_COUNT  output  32  total packets emitted on the output

## Operation
- State: input_select (0/1), packet_counter (16-bit, runs 1..ppg), ppg_reg (16-bit latched group size), 2-entry skid buffer (main + skid, each 512+1 bits with valid flag), PACKET_COUNT.
- ppg_reg = max(PACKETS_PER_GROUP, 1); loaded while in reset and at every group switch. Changes mid-group take effect at the next group.
- Input handshake: in_hs = TVALID[sel] & TREADY[sel]. The unselected input's TREADY is held 0; its TVALID/TDATA/TLAST are ignored.
- TREADY[sel] = ~skid_valid (registered; no combinational path from AXIS_OUT_TREADY).
- On in_hs with TLAST=1: if packet_counter < ppg_reg then packet_counter+1; else packet_counter <= 1, input_select toggles, ppg_reg reloads.
- Skid buffer: on in_hs, beat goes to main if main is empty or being drained this cycle, otherwise to skid. On output handshake (TVALID & TREADY), skid (if valid) moves to main. Never drops or duplicates beats; order preserved.
- AXIS_OUT_* driven directly from main register.
- PACKET_COUNT increments on output handshake with TLAST=1; wraps 0xFFFFFFFF -> 0.
- INPUT_SELECT = input_select.

## Timing
- Reset values: input_select 0, packet_counter 1, both buffer entries empty, AXIS_OUT_TVALID 0, AXIS_OUT_TLAST 0, AXIS_OUT_TDATA 0, PACKET_COUNT 0, AXIS_IN0/1_TREADY 0 during reset, IN0_TREADY 1 on first cycle after reset release.
- Latency: beat accepted at edge N appears on AXIS_OUT at cycle N+1.
- Throughput: 1 beat/cycle sustained, including across input switches — the beat after the group's final TLAST may be taken from the other input on the very next cycle.
- Backpressure: with AXIS_OUT_TREADY low, at most 2 beats accepted, then TREADY[sel] drops the cycle after skid fills; it rises the cycle after the skid drains.
- Switch is triggered only by the input handshake of TLAST; output stalls do not delay or advance it.
- Simultaneous in_hs and out_hs with both entries full cannot occur (TREADY=0); with main full/skid empty, data flows main<-input, no skid use.
- Reset mid-packet: all buffered beats discarded, selection returns to input 0, counter to 1; no partial packet is emitted afterwards.

## Test plan
- PACKETS_PER_GROUP=2, 4-beat packets, both inputs always valid, OUT_TREADY=1 -> output order IN0 pkt, IN0 pkt, IN1 pkt, IN1 pkt, repeating; zero bubbles; TLAST every 4th beat; PACKET_COUNT=8 after 32 beats.
- PACKETS_PER_GROUP=0 -> behaves as 1: strict alternation IN0, IN1, IN0 per packet.
- Random OUT_TREADY (50%) and random per-input TVALID -> output beat sequence matches reference model exactly; IN TREADY never high with skid full; unselected TREADY always 0.
- Change PACKETS_PER_GROUP from 3 to 1 after first packet of a group -> current group still 3 packets, subsequent groups 1.
- Assert resetn=0 for 1 cycle mid-packet with 1 beat buffered -> OUT_TVALID 0 next cycle, INPUT_SELECT 0, PACKET_COUNT 0, next packet drawn from IN0.
- Preload PACKET_COUNT near wrap (force 0xFFFFFFFF) and emit one packet -> PACKET_COUNT=0.
